// File: rtl/ai_crc_stream.sv
// rtl/ai_crc_stream.sv - streaming CRC engine, multi-byte beats folded one byte per clock
module ai_crc_stream #(
    parameter int unsigned           CRC_W      = 32,
    parameter logic [CRC_W-1:0]      POLY       = 32'h04C11DB7,
    parameter logic [CRC_W-1:0]      INIT       = 32'hFFFFFFFF,
    parameter logic [CRC_W-1:0]      XOR_OUT    = 32'hFFFFFFFF,
    parameter bit                    REFIN      = 1'b1,
    parameter bit                    REFOUT     = 1'b1,
    parameter int unsigned           DATA_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*DATA_BYTES-1:0] in_data,
    input  logic [DATA_BYTES-1:0]   in_keep,
    input  logic                    in_last,
    output logic [CRC_W-1:0]        crc_out,
    output logic                    crc_valid,
    output logic                    busy
);

    localparam int unsigned IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t                    state;
    logic [CRC_W-1:0]          acc;
    logic [8*DATA_BYTES-1:0]   data_q;
    logic [DATA_BYTES-1:0]     keep_q;
    logic                      last_q;
    logic [IDX_W-1:0]          idx;
    logic [7:0]                cur_byte;

    // Bit-serial fold of one byte; REFIN picks LSB-first or MSB-first order.
    function automatic logic [CRC_W-1:0] fold_byte(input logic [CRC_W-1:0] a,
                                                   input logic [7:0]       b);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = a;
        for (int i = 0; i < 8; i++) begin
            fb = r[CRC_W-1] ^ (REFIN ? b[i] : b[7-i]);
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
        return r;
    endfunction

    function automatic logic [CRC_W-1:0] reverse(input logic [CRC_W-1:0] a);
        logic [CRC_W-1:0] r;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = a[CRC_W-1-i];
        end
        return r;
    endfunction

    assign cur_byte = data_q[int'(idx)*8 +: 8];
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= INIT;
            data_q    <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
            idx       <= '0;
            crc_out   <= '0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            if (clr) begin
                state <= IDLE;
                acc   <= INIT;
                idx   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid) begin
                            data_q <= in_data;
                            keep_q <= in_keep;
                            last_q <= in_last;
                            idx    <= '0;
                            state  <= RUN;
                        end
                    end
                    RUN: begin
                        // Unkept bytes still burn a cycle so latency never depends on keep.
                        if (keep_q[int'(idx)]) begin
                            acc <= fold_byte(acc, cur_byte);
                        end
                        if (idx == IDX_LAST) begin
                            idx   <= '0;
                            state <= last_q ? FIN : IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    FIN: begin
                        crc_out   <= (REFOUT ? reverse(acc) : acc) ^ XOR_OUT;
                        crc_valid <= 1'b1;
                        acc       <= INIT;
                        state     <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        acc   <= INIT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ai_crc_stream.sv
// tb/tb_ai_crc_stream.sv - directed, table-driven bench for ai_crc_stream
module tb_ai_crc_stream;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;

    logic        a_valid;
    logic        a_ready;
    logic [31:0] a_data;
    logic [3:0]  a_keep;
    logic        a_last;
    logic [31:0] a_crc;
    logic        a_crc_valid;
    logic        a_busy;

    logic        b_valid;
    logic        b_ready;
    logic [7:0]  b_data;
    logic [0:0]  b_keep;
    logic        b_last;
    logic [31:0] b_crc;
    logic        b_crc_valid;
    logic        b_busy;

    always #5 clk = ~clk;

    ai_crc_stream dut_a (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
        .in_keep(a_keep), .in_last(a_last),
        .crc_out(a_crc), .crc_valid(a_crc_valid), .busy(a_busy)
    );

    ai_crc_stream #(
        .XOR_OUT(32'h0), .REFIN(1'b0), .REFOUT(1'b0), .DATA_BYTES(1)
    ) dut_b (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .in_keep(b_keep), .in_last(b_last),
        .crc_out(b_crc), .crc_valid(b_crc_valid), .busy(b_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready_a();
        int i;
        for (i = 0; i < 50; i++) begin
            if (a_ready) break;
            @(posedge clk); #1;
        end
        if (i == 50) check("a_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_a(input logic [31:0] d, input logic [3:0] k, input logic l,
                          input logic [31:0] exp);
        int fin;
        wait_ready_a();
        a_data = d; a_keep = k; a_last = l; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        fin = DB + (l ? 1 : 0);
        for (int c = 1; c <= fin; c++) begin
            @(posedge clk); #1;
            check("a_ready_lat", a_ready, c == fin);
            check("a_crc_valid_lat", a_crc_valid, l && (c == fin));
            if (c == 1) check("a_busy", a_busy, 1'b1);
        end
        if (l) begin
            check("a_crc_out", a_crc, exp);
            @(posedge clk); #1;
            check("a_pulse_len", a_crc_valid, 1'b0);
            check("a_crc_hold", a_crc, exp);
        end
    endtask

    task automatic send_msg_a();
        send_a(32'h34333231, 4'hF, 1'b0, 32'h0);
        send_a(32'h38373635, 4'hF, 1'b0, 32'h0);
        send_a(32'h00000039, 4'h1, 1'b1, 32'hCBF43926);
    endtask

    task automatic send_b(input logic [7:0] d, input logic l, input logic [31:0] exp);
        int i;
        for (i = 0; i < 50; i++) begin
            if (b_ready) break;
            @(posedge clk); #1;
        end
        if (i == 50) check("b_ready_timeout", 64'd0, 64'd1);
        b_data = d; b_keep = 1'b1; b_last = l; b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
        if (!l) begin
            @(posedge clk); #1;
            check("b_ready_run", b_ready, 1'b1);
        end else begin
            @(posedge clk); #1;
            check("b_ready_fin", b_ready, 1'b0);
            @(posedge clk); #1;
            check("b_ready_after", b_ready, 1'b1);
            check("b_crc_valid", b_crc_valid, 1'b1);
            check("b_crc_out", b_crc, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];
    int   pulses;

    initial begin
        vecs[0] = '{32'h34333231, 4'hF, 1'b0, 32'h0};
        vecs[1] = '{32'h38373635, 4'hF, 1'b0, 32'h0};
        vecs[2] = '{32'h00000039, 4'h1, 1'b1, 32'hCBF43926};
        vecs[3] = '{32'hDEADBEEF, 4'h0, 1'b1, 32'h00000000};
        vecs[4] = '{32'hDEADBEEF, 4'h0, 1'b1, 32'h00000000};
        vecs[5] = '{32'h32AA31BB, 4'hA, 1'b0, 32'h0};
        vecs[6] = '{32'h36353433, 4'hF, 1'b0, 32'h0};
        vecs[7] = '{32'h39CC3837, 4'hB, 1'b1, 32'hCBF43926};
        vecs[8] = '{32'h00000000, 4'h0, 1'b1, 32'h00000000};

        rst = 1'b0; clr = 1'b0;
        a_valid = 1'b0; a_data = '0; a_keep = '0; a_last = 1'b0;
        b_valid = 1'b0; b_data = '0; b_keep = '0; b_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_crc_out", a_crc, 32'h0);
        check("rst_crc_valid", a_crc_valid, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", a_ready, 1'b1);
        check("rst_busy", a_busy, 1'b0);

        for (int i = 0; i < 9; i++) begin
            send_a(vecs[i].data, vecs[i].keep, vecs[i].last, vecs[i].exp);
        end

        // in_valid held high through RUN with changing data
        wait_ready_a();
        a_data = 32'h34333231; a_keep = 4'hF; a_last = 1'b0; a_valid = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= DB; c++) begin
            a_data = $urandom; a_keep = 4'(c); a_last = 1'(c);
            @(posedge clk); #1;
            check("held_ready", a_ready, c == DB);
        end
        a_valid = 1'b0;
        send_a(32'h38373635, 4'hF, 1'b0, 32'h0);
        send_a(32'h00000039, 4'h1, 1'b1, 32'hCBF43926);

        // clr abort mid-RUN, then a beat presented alongside clr in IDLE
        send_a(32'hDEADBEEF, 4'h0, 1'b1, 32'h00000000);
        pulses = 0;
        a_data = 32'h34333231; a_keep = 4'hF; a_last = 1'b0; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check("clr_ready", a_ready, 1'b1);
        check("clr_busy", a_busy, 1'b0);
        check("clr_crc_hold", a_crc, 32'h0);
        a_data = 32'h31313131; a_keep = 4'hF; a_last = 1'b1; a_valid = 1'b1; clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; a_valid = 1'b0;
        check("clr_no_accept", a_ready, 1'b1);
        for (int c = 0; c < 8; c++) begin
            if (a_crc_valid) pulses++;
            @(posedge clk); #1;
        end
        check("clr_no_pulse", pulses, 0);
        send_msg_a();

        for (int i = 0; i < 9; i++) begin
            send_b(8'h31 + 8'(i), i == 8, 32'h0376E6E7);
        end

        // asynchronous reset mid-message
        wait_ready_a();
        a_data = 32'h34333231; a_keep = 4'hF; a_last = 1'b0; a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("arst_ready", a_ready, 1'b1);
        check("arst_crc_out", a_crc, 32'h0);
        check("arst_busy", a_busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        send_msg_a();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
